// File: rtl/msk_demod_uart_framer.sv
// -----------------------------------------------------------------------------
// msk_demod_uart_framer
//
// Purpose:
//   Takes 64-bit words from the MSK demodulator and streams each one to the PC
//   as a 10-byte UART 8N1 frame: {HEADER_BYTE, d[63:56] .. d[7:0], chk}, where
//   chk is the XOR of the 8 data bytes. A 2-entry FIFO holds words that arrive
//   while a frame is still being shifted out; further words are dropped and
//   counted.
//
// Ports:
//   logic_clk_in   in   1   logic clock, the only clock
//   logic_rst_in   in   1   synchronous, active-high reset
//   data_in        in   64  demodulated word, sampled only on a push edge
//   data_in_valid  in   1   level; a 0->1 transition marks a new word
//   uart_tx        out  1   UART serial output, idle high, driven from a flop
//   tx_busy        out  1   high while a frame is being shifted out
//   overflow_cnt   out  8   words dropped on a full FIFO, saturates at 255
//   frame_cnt      out  16  frames fully sent, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module msk_demod_uart_framer #(
    parameter int unsigned CLKS_PER_BIT = 1736,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic        logic_clk_in,
    input  logic        logic_rst_in,
    input  logic [63:0] data_in,
    input  logic        data_in_valid,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic [7:0]  overflow_cnt,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [63:0] mem_q [2];
    logic [63:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [63:0] word_q, word_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic        uart_tx_q, uart_tx_d;
    logic        tx_busy_q, tx_busy_d;
    logic [7:0]  overflow_q, overflow_d;
    logic [15:0] frame_q, frame_d;

    logic        rise, push, pop, fifo_empty, fifo_full, bit_end;
    logic [7:0]  data_byte [8];
    logic [7:0]  chk;
    logic [7:0]  cur_byte;

    // Byte currently on the wire: header, data bytes MSB first, checksum.
    always_comb begin
        chk = 8'h00;
        for (int i = 0; i < 8; i++) begin
            data_byte[i] = word_q[8*(7-i) +: 8];
            chk          = chk ^ data_byte[i];
        end
        if (byte_idx_q == 4'd0)
            cur_byte = HEADER_BYTE;
        else if (byte_idx_q == 4'd9)
            cur_byte = chk;
        else
            cur_byte = data_byte[3'(byte_idx_q - 4'd1)];
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d    = state_q;
        valid_d    = data_in_valid;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        uart_tx_d  = uart_tx_q;
        tx_busy_d  = tx_busy_q;
        overflow_d = overflow_q;
        frame_d    = frame_q;
        pop        = 1'b0;

        rise       = data_in_valid & ~valid_q;
        fifo_empty = (count_q == 2'd0);
        fifo_full  = (count_q == 2'd2);
        bit_end    = (clk_cnt_q == 16'(CLKS_PER_BIT - 1));
        clk_cnt_d  = bit_end ? 16'd0 : clk_cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                clk_cnt_d = 16'd0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_d    = START;
                    byte_idx_d = 4'd0;
                    uart_tx_d  = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    uart_tx_d = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        uart_tx_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        uart_tx_d = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q != 4'd9) begin
                        byte_idx_d = byte_idx_q + 4'd1;
                        state_d    = START;
                        uart_tx_d  = 1'b0;
                    end else begin
                        frame_d = frame_q + 16'd1;
                        if (!fifo_empty) begin
                            // Back-to-back frame: no idle gap after the stop bit.
                            pop        = 1'b1;
                            state_d    = START;
                            byte_idx_d = 4'd0;
                            uart_tx_d  = 1'b0;
                        end else begin
                            state_d   = IDLE;
                            uart_tx_d = 1'b1;
                            tx_busy_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            word_d   = mem_q[rd_ptr_q];
            rd_ptr_d = ~rd_ptr_q;
        end

        // A pop on the same edge frees a slot, so a push into a full FIFO is kept.
        push = rise & (~fifo_full | pop);
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rise && !push && overflow_q != 8'hFF)
            overflow_d = overflow_q + 8'd1;

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge logic_clk_in) begin
        if (logic_rst_in) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            byte_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            clk_cnt_q  <= 16'd0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            overflow_q <= 8'd0;
            frame_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            clk_cnt_q  <= clk_cnt_d;
            uart_tx_q  <= uart_tx_d;
            tx_busy_q  <= tx_busy_d;
            overflow_q <= overflow_d;
            frame_q    <= frame_d;
        end
    end

    // NOTE: payload storage has no reset; count_q and state_q gate every read, so reset values would never be observed.
    always_ff @(posedge logic_clk_in) begin
        mem_q  <= mem_d;
        word_q <= word_d;
    end

    assign uart_tx      = uart_tx_q;
    assign tx_busy      = tx_busy_q;
    assign overflow_cnt = overflow_q;
    assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_msk_demod_uart_framer.sv
// -----------------------------------------------------------------------------
// tb_msk_demod_uart_framer
//
// Directed stimulus pushes the hand-computed byte sequence of every frame it
// expects into exp_q; an independent UART receiver samples uart_tx mid-bit,
// rebuilds each byte and compares it against the head of exp_q.
// -----------------------------------------------------------------------------
module tb_msk_demod_uart_framer;

    localparam int CPB = 4;

    logic        logic_clk_in = 1'b0;
    logic        logic_rst_in = 1'b1;
    logic [63:0] data_in      = 64'h0;
    logic        data_in_valid = 1'b0;
    logic        uart_tx;
    logic        tx_busy;
    logic [7:0]  overflow_cnt;
    logic [15:0] frame_cnt;

    msk_demod_uart_framer #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(8'hA5)) dut (
        .logic_clk_in (logic_clk_in),
        .logic_rst_in (logic_rst_in),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .uart_tx      (uart_tx),
        .tx_busy      (tx_busy),
        .overflow_cnt (overflow_cnt),
        .frame_cnt    (frame_cnt)
    );

    always #5 logic_clk_in = ~logic_clk_in;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];
    int         start_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- UART receiver / scoreboard monitor ----------------
    int         cyc = 0;
    bit         rx_active = 1'b0;
    logic       prev = 1'b1;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge logic_clk_in) begin
        cyc++;
        if (logic_rst_in) begin
            rx_active = 1'b0;
            prev      = 1'b1;
        end else if (!rx_active) begin
            if (prev && !uart_tx) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                start_q.push_back(cyc);
            end
            prev = uart_tx;
        end else begin
            rx_cnt++;
            if (rx_cnt == 2) begin
                check("start_bit", 64'(uart_tx), 64'd0);
            end else if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 2) % 4) == 0) begin
                rx_byte[(rx_cnt - 6) / 4] = uart_tx;
            end else if (rx_cnt == 38) begin
                check("stop_bit", 64'(uart_tx), 64'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", rx_byte, $time);
                end else begin
                    check("rx_byte", 64'(rx_byte), 64'(exp_q.pop_front()));
                end
                rx_active = 1'b0;
                prev      = uart_tx;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge logic_clk_in);
        #1;
    endtask

    task automatic expect_frame(input logic [63:0] w, input logic [7:0] chk);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[8*(7-i) +: 8]);
        exp_q.push_back(chk);
    endtask

    // Rise sampled on the next edge, then valid low for one edge.
    task automatic push_word(input logic [63:0] w, input logic [7:0] chk, input bit sent);
        if (sent) expect_frame(w, chk);
        data_in       = w;
        data_in_valid = 1'b1;
        tick(1);
        data_in_valid = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin
            tick(1);
            n++;
        end
        check("idle_timeout", 64'(n >= budget), 64'd0);
    endtask

    task automatic do_reset();
        logic_rst_in = 1'b1;
        exp_q.delete();
        tick(2);
        logic_rst_in = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] f0;

        // Reset state
        tick(2);
        do_reset();
        check("rst_uart_tx", 64'(uart_tx), 64'd1);
        check("rst_tx_busy", 64'(tx_busy), 64'd0);
        check("rst_overflow", 64'(overflow_cnt), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        // 1. Basic frame and latency; chk(0123456789ABCDEF) = 00
        expect_frame(64'h0123456789ABCDEF, 8'h00);
        data_in       = 64'h0123456789ABCDEF;
        data_in_valid = 1'b1;
        tick(1);                                   // push edge E
        check("t1_tx_at_push", 64'(uart_tx), 64'd1);
        check("t1_busy_at_push", 64'(tx_busy), 64'd0);
        data_in_valid = 1'b0;
        data_in       = 64'hDEAD_DEAD_DEAD_DEAD;   // ignored off the push edge
        tick(1);                                   // S = E+1
        check("t1_start_bit", 64'(uart_tx), 64'd0);
        check("t1_busy", 64'(tx_busy), 64'd1);
        tick(399);
        check("t1_busy_last_clk", 64'(tx_busy), 64'd1);
        check("t1_frame_cnt_before", 64'(frame_cnt), 64'd0);
        tick(1);
        check("t1_busy_done", 64'(tx_busy), 64'd0);
        check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        tick(5);

        // 2. Checksum: FF^FF^FF^FF^00^00^00^01 = 01
        push_word(64'hFFFFFFFF00000001, 8'h01, 1'b1);
        wait_idle(1000);
        check("t2_frame_cnt", 64'(frame_cnt), 64'd2);
        tick(5);

        // 3. Four rises 10 clocks apart: three back-to-back frames, one drop
        start_q.delete();
        f0 = frame_cnt;
        push_word(64'h1111111111111111, 8'h00, 1'b1);
        tick(8);
        push_word(64'h0102040810204080, 8'hFF, 1'b1);
        tick(8);
        push_word(64'hDEADBEEF00000000, 8'h22, 1'b1);
        tick(8);
        push_word(64'hCAFEBABECAFEBABE, 8'h00, 1'b0);
        check("t3_overflow", 64'(overflow_cnt), 64'd1);
        wait_idle(2000);
        check("t3_frames", 64'(frame_cnt - f0), 64'd3);
        check("t3_byte_count", 64'(start_q.size()), 64'd30);
        if (start_q.size() == 30)
            check("t3_no_gap", 64'(start_q[29] - start_q[0]), 64'd1160);
        tick(5);

        // 4. Push on the edge the last stop bit ends, FIFO full
        f0 = frame_cnt;
        push_word(64'hA1A2A3A4A5A6A7A8, 8'h08, 1'b1);  // rise E
        tick(3);
        push_word(64'h0000000000000000, 8'h00, 1'b1);  // rise E+5
        tick(3);
        push_word(64'h8000000000000001, 8'h81, 1'b1);  // rise E+10
        tick(389);
        push_word(64'h00FF00FF00FF00FF, 8'h00, 1'b1);  // rise E+401 = pop edge
        check("t4_overflow_same", 64'(overflow_cnt), 64'd1);
        wait_idle(3000);
        check("t4_frames", 64'(frame_cnt - f0), 64'd4);
        tick(5);

        // 5. Reset during byte 4 of a frame
        push_word(64'h5555AAAA5555AAAA, 8'h00, 1'b1);   // S = E+1, now S+1ns
        tick(169);                                      // inside byte 4
        logic_rst_in = 1'b1;
        exp_q.delete();
        tick(1);
        check("t5_rst_tx", 64'(uart_tx), 64'd1);
        check("t5_rst_busy", 64'(tx_busy), 64'd0);
        check("t5_rst_frame", 64'(frame_cnt), 64'd0);
        check("t5_rst_ovf", 64'(overflow_cnt), 64'd0);
        tick(1);
        logic_rst_in = 1'b0;
        tick(20);
        check("t5_tx_idle", 64'(uart_tx), 64'd1);
        check("t5_busy_idle", 64'(tx_busy), 64'd0);
        push_word(64'h0123456789ABCDEF, 8'h00, 1'b1);
        wait_idle(1000);
        check("t5_frame_cnt", 64'(frame_cnt), 64'd1);
        tick(5);

        // 6a. Held valid gives exactly one frame
        f0 = frame_cnt;
        expect_frame(64'h7766554433221100, 8'h00);
        data_in       = 64'h7766554433221100;
        data_in_valid = 1'b1;
        tick(1000);
        data_in_valid = 1'b0;
        tick(1);
        wait_idle(1000);
        check("t6_one_frame", 64'(frame_cnt - f0), 64'd1);
        tick(5);

        // 6b. Overflow saturation: 320 rises every 2 clocks with FIFO full
        do_reset();
        push_word(64'h1010101010101010, 8'h00, 1'b1);   // rise E
        push_word(64'h2020202020202021, 8'h01, 1'b1);   // rise E+2
        push_word(64'h3030303030303030, 8'h00, 1'b1);   // rise E+4
        for (int k = 0; k < 320; k++) begin
            // rise at E+6+2k; E+402 (k=198) follows the pop at E+401
            push_word(64'h4040404040404042, 8'h02, (k == 198));
            if (k == 197) check("t6_ovf_198", 64'(overflow_cnt), 64'd198);
        end
        check("t6_ovf_sat", 64'(overflow_cnt), 64'd255);
        wait_idle(3000);
        check("t6_sat_frames", 64'(frame_cnt), 64'd4);
        tick(50);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
